frame_capture: RTL and testbench



---
 rtl/frame_pkg.sv | 18 +
 rtl/frame_dp_ram.sv | 39 +++
 rtl/frame_capture.sv | 148 ++++++++++++++
 tb/tb_frame_capture.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// Shared defaults and types for the frame capture write path.
package frame_pkg;

    localparam int ROWS_DEFAULT    = 128;
    localparam int COLS_DEFAULT    = 128;
    localparam int PIXEL_W_DEFAULT = 10;
    localparam int ADDR_W_DEFAULT  = 7;

    // Capture controller states.
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DONE    = 2'd2
    } cap_state_t;

    typedef logic [PIXEL_W_DEFAULT-1:0] pixel_t;

endpackage

// File: rtl/frame_dp_ram.sv
// Simple dual-port frame RAM: one write port, one registered read port.
// A read and a write to the same address on one edge return the old data.
module frame_dp_ram #(
    parameter int DEPTH = 16384,
    parameter int AW    = 14,
    parameter int DW    = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    // Array write; the array itself is never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Registered read; the output register holds when no read is issued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/frame_capture.sv
// Frame capture: stores a raster-order pixel stream into a ROWS x COLS
// buffer with internally generated addresses, and offers a 1-cycle read port.
module frame_capture
    import frame_pkg::*;
#(
    parameter int ROWS    = ROWS_DEFAULT,
    parameter int COLS    = COLS_DEFAULT,
    parameter int PIXEL_W = PIXEL_W_DEFAULT,
    parameter int ADDR_W  = ADDR_W_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [PIXEL_W-1:0] pixel_w,
    input  logic               pixel_w_valid,
    input  logic [ADDR_W-1:0]  row_r,
    input  logic [ADDR_W-1:0]  col_r,
    input  logic               addr_r_valid,
    output logic [PIXEL_W-1:0] pixel_r,
    output logic               pixel_r_valid,
    output logic               busy,
    output logic               frame_done,
    output logic               overrun
);

    localparam int DEPTH  = ROWS * COLS;
    localparam int MEM_AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    cap_state_t          state_q, state_d;
    logic [ADDR_W-1:0]   row_q, row_d;
    logic [ADDR_W-1:0]   col_q, col_d;
    logic                overrun_q, overrun_d;
    logic                done_q, done_d;
    logic                we;
    logic [MEM_AW-1:0]   waddr;

    logic                rd_in_range;
    logic                rd_en;
    logic [MEM_AW-1:0]   raddr;
    logic                rd_valid_q;
    logic                rd_oor_q;
    logic [PIXEL_W-1:0]  ram_rdata;

    logic                last_col;
    logic                last_pix;

    assign last_col = (int'(col_q) == COLS - 1);
    assign last_pix = last_col && (int'(row_q) == ROWS - 1);
    assign waddr    = MEM_AW'(int'(row_q) * COLS + int'(col_q));

    // State, counters and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            row_q     <= '0;
            col_q     <= '0;
            overrun_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            overrun_q <= overrun_d;
            done_q    <= done_d;
        end
    end

    // Next-state: start wins over a same-cycle pixel; pixels outside CAPTURE flag overrun.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        overrun_d = overrun_q;
        done_d    = 1'b0;
        we        = 1'b0;
        if (start) begin
            state_d   = CAPTURE;
            row_d     = '0;
            col_d     = '0;
            overrun_d = 1'b0;
        end else if (pixel_w_valid) begin
            case (state_q)
                CAPTURE: begin
                    we = 1'b1;
                    if (last_pix) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        row_d   = '0;
                        col_d   = '0;
                    end else if (last_col) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
                default: begin
                    overrun_d = 1'b1;
                end
            endcase
        end
    end

    // Read address check; out-of-range reads skip the RAM and return zero.
    always_comb begin
        rd_in_range = (int'(row_r) < ROWS) && (int'(col_r) < COLS);
        rd_en       = addr_r_valid && rd_in_range;
        raddr       = '0;
        if (rd_in_range) begin
            raddr = MEM_AW'(int'(row_r) * COLS + int'(col_r));
        end
    end

    // Read response tracking; rd_oor_q only changes on a read so pixel_r holds otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_oor_q   <= 1'b0;
        end else begin
            rd_valid_q <= addr_r_valid;
            if (addr_r_valid) begin
                rd_oor_q <= !rd_in_range;
            end
        end
    end

    frame_dp_ram #(
        .DEPTH (DEPTH),
        .AW    (MEM_AW),
        .DW    (PIXEL_W)
    ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (pixel_w),
        .re_i    (rd_en),
        .raddr_i (raddr),
        .rdata_o (ram_rdata)
    );

    assign pixel_r       = rd_oor_q ? '0 : ram_rdata;
    assign pixel_r_valid = rd_valid_q;
    assign busy          = (state_q == CAPTURE);
    assign frame_done    = done_q;
    assign overrun       = overrun_q;

endmodule

// File: tb/tb_frame_capture.sv
// Self-checking bench for frame_capture: table-driven readback plus
// hand-written multi-cycle sequences.
module tb_frame_capture;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [9:0] pixel_w = '0;
    logic       pixel_w_valid = 1'b0;
    logic [6:0] row_r = '0;
    logic [6:0] col_r = '0;
    logic       addr_r_valid = 1'b0;
    logic [9:0] pixel_r;
    logic       pixel_r_valid;
    logic       busy;
    logic       frame_done;
    logic       overrun;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;

    typedef struct {
        int    row;
        int    col;
        int    exp;
        string name;
    } rd_vec_t;

    rd_vec_t vecs[8];

    frame_capture #(
        .ROWS    (128),
        .COLS    (128),
        .PIXEL_W (10),
        .ADDR_W  (7)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .pixel_w       (pixel_w),
        .pixel_w_valid (pixel_w_valid),
        .row_r         (row_r),
        .col_r         (col_r),
        .addr_r_valid  (addr_r_valid),
        .pixel_r       (pixel_r),
        .pixel_r_valid (pixel_r_valid),
        .busy          (busy),
        .frame_done    (frame_done),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (frame_done === 1'b1) done_cnt++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic rd(input string name, input int r, input int c, input int exp);
        row_r        = 7'(r);
        col_r        = 7'(c);
        addr_r_valid = 1'b1;
        tick();
        addr_r_valid = 1'b0;
        check({name, "_valid"}, {31'b0, pixel_r_valid}, 32'd1);
        check(name, {22'b0, pixel_r}, 32'(exp));
    endtask

    task automatic wr(input int val);
        pixel_w       = 10'(val);
        pixel_w_valid = 1'b1;
        tick();
        pixel_w_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        tick();
    endtask

    initial begin
        int gap;
        int dc;

        // Readback table after the full frame: value at index i is i mod 1024.
        vecs[0] = '{0,   0,   0,    "full_0_0"};
        vecs[1] = '{0,   127, 127,  "full_0_127"};
        vecs[2] = '{1,   0,   128,  "full_1_0"};
        vecs[3] = '{127, 127, 1023, "full_127_127"};
        vecs[4] = '{64,  3,   3,    "full_64_3"};
        vecs[5] = '{2,   5,   261,  "full_2_5"};
        vecs[6] = '{7,   127, 1023, "full_7_127"};
        vecs[7] = '{8,   0,   0,    "full_8_0"};

        // Reset state
        #12 rst_n = 1'b1;
        tick();
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, frame_done}, 0);
        check("rst_overrun", {31'b0, overrun}, 0);
        check("rst_pixel_r", {22'b0, pixel_r}, 0);
        check("rst_pixel_r_valid", {31'b0, pixel_r_valid}, 0);

        // Full frame, one pixel every two cycles
        pulse_start();
        check("busy_after_start", {31'b0, busy}, 1);
        for (int i = 0; i < 16384; i++) begin
            if (i == 16383) check("no_early_done", 32'(done_cnt), 0);
            wr(i % 1024);
            if (i == 16383) begin
                check("done_after_last", {31'b0, frame_done}, 1);
                check("busy_low_after_last", {31'b0, busy}, 0);
            end
            tick();
        end
        check("done_one_cycle", {31'b0, frame_done}, 0);
        tick();
        check("done_pulse_count", 32'(done_cnt), 1);
        check("busy_low_done", {31'b0, busy}, 0);

        foreach (vecs[k]) rd(vecs[k].name, vecs[k].row, vecs[k].col, vecs[k].exp);

        // Back-to-back pipelined reads
        row_r = 7'd0; col_r = 7'd3; addr_r_valid = 1'b1;
        tick();
        check("pipe_a", {22'b0, pixel_r}, 3);
        row_r = 7'd0; col_r = 7'd9;
        tick();
        check("pipe_b", {22'b0, pixel_r}, 9);
        addr_r_valid = 1'b0;
        tick();
        check("pipe_valid_low", {31'b0, pixel_r_valid}, 0);
        check("pipe_hold", {22'b0, pixel_r}, 9);

        // Gaps and row wrap
        pulse_start();
        for (int i = 0; i < 130; i++) begin
            wr(i);
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) tick();
        end
        check("gap_busy", {31'b0, busy}, 1);
        rd("gap_0_127", 0, 127, 127);
        rd("gap_1_0", 1, 0, 128);
        rd("gap_1_1", 1, 1, 129);
        rd("gap_1_2_old", 1, 2, 130);

        // Overrun in IDLE
        do_reset();
        check("ovr_clear_rst", {31'b0, overrun}, 0);
        for (int i = 0; i < 3; i++) wr(10'h2AA);
        check("ovr_set", {31'b0, overrun}, 1);
        tick();
        check("ovr_sticky", {31'b0, overrun}, 1);
        rd("ovr_mem_0_0", 0, 0, 0);
        rd("ovr_mem_0_1", 0, 1, 1);
        pulse_start();
        check("ovr_cleared_by_start", {31'b0, overrun}, 0);

        // start coinciding with a valid pixel, from IDLE
        do_reset();
        start = 1'b1; pixel_w = 10'h3FF; pixel_w_valid = 1'b1;
        tick();
        start = 1'b0; pixel_w_valid = 1'b0;
        check("sv_overrun", {31'b0, overrun}, 0);
        check("sv_busy", {31'b0, busy}, 1);
        rd("sv_not_written", 0, 0, 0);
        wr(10'h0AB);
        rd("sv_first_at_0_0", 0, 0, 10'h0AB);
        rd("sv_0_1_untouched", 0, 1, 1);

        // Same-address collision at (0,5): old value 5 from the gap test
        for (int i = 1; i <= 4; i++) wr(10'h10 + i);
        pixel_w = 10'h155; pixel_w_valid = 1'b1;
        row_r = 7'd0; col_r = 7'd5; addr_r_valid = 1'b1;
        tick();
        pixel_w_valid = 1'b0; addr_r_valid = 1'b0;
        check("coll_old", {22'b0, pixel_r}, 5);
        rd("coll_new", 0, 5, 10'h155);

        // Reset mid-frame after 500 pixels
        dc = done_cnt;
        pulse_start();
        for (int i = 0; i < 500; i++) wr(10'h100 + i);
        rd("mid_0_3", 0, 3, 10'h103);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_busy", {31'b0, busy}, 0);
        check("mid_rst_done", {31'b0, frame_done}, 0);
        check("mid_rst_overrun", {31'b0, overrun}, 0);
        check("mid_rst_pixel_r", {22'b0, pixel_r}, 0);
        check("mid_rst_valid", {31'b0, pixel_r_valid}, 0);
        #10 rst_n = 1'b1;
        tick();
        check("mid_idle", {31'b0, busy}, 0);
        rd("mid_0_10_kept", 0, 10, 10'h10A);
        rd("mid_3_115_kept", 3, 115, 10'h100 + 499);
        wr(10'h3C3);
        check("mid_idle_is_idle", {31'b0, overrun}, 1);
        check("mid_no_done", 32'(done_cnt - dc), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
